// File: rtl/reg_read_lane_if.sv
// Issue / PRF / bypass / execute signal bundle for reg_read_lane.
// The slave modport is the stage itself; the master modport is its environment.
interface reg_read_lane_if #(
    parameter int unsigned INDEX   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PAYLOAD = 16,
    parameter int unsigned NUM_BYP = 2
);
    logic                       flush_i;
    logic                       iss_valid_i;
    logic                       iss_ready_o;
    logic [INDEX-1:0]           iss_src1_i;
    logic [INDEX-1:0]           iss_src2_i;
    logic [PAYLOAD-1:0]         iss_payload_i;
    logic [INDEX-1:0]           prf_addr1_o;
    logic [INDEX-1:0]           prf_addr2_o;
    logic [WIDTH-1:0]           prf_data1_i;
    logic [WIDTH-1:0]           prf_data2_i;
    logic [NUM_BYP-1:0]         byp_valid_i;
    logic [NUM_BYP*INDEX-1:0]   byp_tag_i;
    logic [NUM_BYP*WIDTH-1:0]   byp_data_i;
    logic                       exe_valid_o;
    logic                       exe_ready_i;
    logic [WIDTH-1:0]           exe_op1_o;
    logic [WIDTH-1:0]           exe_op2_o;
    logic [PAYLOAD-1:0]         exe_payload_o;

    modport master (
        output flush_i, iss_valid_i, iss_src1_i, iss_src2_i, iss_payload_i,
        output prf_data1_i, prf_data2_i, byp_valid_i, byp_tag_i, byp_data_i, exe_ready_i,
        input  iss_ready_o, prf_addr1_o, prf_addr2_o,
        input  exe_valid_o, exe_op1_o, exe_op2_o, exe_payload_o
    );

    modport slave (
        input  flush_i, iss_valid_i, iss_src1_i, iss_src2_i, iss_payload_i,
        input  prf_data1_i, prf_data2_i, byp_valid_i, byp_tag_i, byp_data_i, exe_ready_i,
        output iss_ready_o, prf_addr1_o, prf_addr2_o,
        output exe_valid_o, exe_op1_o, exe_op2_o, exe_payload_o
    );
endinterface

// File: rtl/reg_read_lane.sv
// Register-read stage: PRF read, optional writeback bypass, 2-entry skid buffer to execute.
// Define RR_BYPASS_EN to compile in the bypass compare/mux (lowest source index wins).
module reg_read_lane #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned INDEX   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PAYLOAD = 16,
    parameter int unsigned NUM_BYP = 2
) (
    input logic            clk,
    input logic            reset_n,
    reg_read_lane_if.slave bus
);
    localparam int unsigned ENTRY = 2 * WIDTH + PAYLOAD;

    logic [ENTRY-1:0] buf_q [2];
    logic [ENTRY-1:0] buf_d [2];
    logic [ENTRY-1:0] head_q, head_d;
    logic [1:0]       count_q, count_d;
    logic             rptr_q, rptr_d;
    logic             ready_q, ready_d;
    logic             wptr, push, pop;
    logic [WIDTH-1:0] op1, op2;

    // DEPTH is fully implied by INDEX; kept only as a documented parameter.
    logic unused_depth;
    assign unused_depth = (DEPTH != (32'd1 << INDEX));

    assign bus.prf_addr1_o = bus.iss_src1_i;
    assign bus.prf_addr2_o = bus.iss_src2_i;

`ifdef RR_BYPASS_EN
    always_comb begin
        op1 = bus.prf_data1_i;
        op2 = bus.prf_data2_i;
        // Walk from the highest source down so the lowest matching index overrides last.
        for (int k = int'(NUM_BYP) - 1; k >= 0; k--) begin
            if (bus.byp_valid_i[k] && (bus.byp_tag_i[k*INDEX +: INDEX] == bus.iss_src1_i)) begin
                op1 = bus.byp_data_i[k*WIDTH +: WIDTH];
            end
            if (bus.byp_valid_i[k] && (bus.byp_tag_i[k*INDEX +: INDEX] == bus.iss_src2_i)) begin
                op2 = bus.byp_data_i[k*WIDTH +: WIDTH];
            end
        end
    end
`else
    assign op1 = bus.prf_data1_i;
    assign op2 = bus.prf_data2_i;

    logic unused_byp;
    assign unused_byp = ^{bus.byp_valid_i, bus.byp_tag_i, bus.byp_data_i};
`endif

    always_comb begin
        push    = bus.iss_valid_i & ready_q & ~bus.flush_i;
        pop     = (count_q != 2'd0) & bus.exe_ready_i & ~bus.flush_i;
        wptr    = rptr_q ^ count_q[0];
        buf_d   = buf_q;
        count_d = count_q;
        rptr_d  = rptr_q;
        if (push) begin
            buf_d[wptr] = {op1, op2, bus.iss_payload_i};
        end
        if (bus.flush_i) begin
            count_d = 2'd0;
            rptr_d  = 1'b0;
        end else begin
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
        end
        ready_d = (count_d != 2'd2);
        // Outputs are a registered copy of the head so they hold when the buffer drains.
        head_d  = (count_d != 2'd0) ? buf_d[rptr_d] : head_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            head_q   <= '0;
            count_q  <= 2'd0;
            rptr_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            buf_q[0] <= buf_d[0];
            buf_q[1] <= buf_d[1];
            head_q   <= head_d;
            count_q  <= count_d;
            rptr_q   <= rptr_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.iss_ready_o = ready_q;
    assign bus.exe_valid_o = (count_q != 2'd0);
    assign {bus.exe_op1_o, bus.exe_op2_o, bus.exe_payload_o} = head_q;
endmodule

// File: tb/tb_reg_read_lane.sv
// Directed bench for reg_read_lane: operand-resolution vector table plus handshake sequences.
// Expected operands follow RR_BYPASS_EN when it is defined for the build.
module tb_reg_read_lane;
    logic clk = 1'b0;
    logic reset_n;
    int   passed = 0;
    int   total  = 0;
    logic [7:0] prf [16];

`ifdef RR_BYPASS_EN
    localparam bit BypOn = 1'b1;
`else
    localparam bit BypOn = 1'b0;
`endif

    typedef struct {
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [15:0] pl;
        logic [1:0]  bv;
        logic [7:0]  btag;
        logic [15:0] bdata;
        logic [7:0]  e1b;
        logic [7:0]  e2b;
        logic [7:0]  e1n;
        logic [7:0]  e2n;
    } vec_t;

    vec_t vecs [6];

    reg_read_lane_if #(.INDEX(4), .WIDTH(8), .PAYLOAD(16), .NUM_BYP(2)) bus ();

    reg_read_lane #(
        .DEPTH(16), .INDEX(4), .WIDTH(8), .PAYLOAD(16), .NUM_BYP(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.prf_data1_i = prf[bus.prf_addr1_o];
    assign bus.prf_data2_i = prf[bus.prf_addr2_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic issue(input logic [15:0] pl);
        bus.iss_valid_i   = 1'b1;
        bus.iss_src1_i    = 4'd3;
        bus.iss_src2_i    = 4'd5;
        bus.iss_payload_i = pl;
        bus.byp_valid_i   = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) prf[i] = 8'h40 + 8'(i);
        prf[3] = 8'h11;
        prf[5] = 8'h22;
        prf[7] = 8'h00;

        vecs[0] = '{4'd3,  4'd5,  16'hBEEF, 2'b00, 8'h00, 16'h0000, 8'h11, 8'h22, 8'h11, 8'h22};
        vecs[1] = '{4'd7,  4'd2,  16'h1111, 2'b11, 8'h77, 16'hB0A0, 8'hA0, 8'h42, 8'h00, 8'h42};
        vecs[2] = '{4'd9,  4'd9,  16'h2222, 2'b10, 8'h99, 16'h5C77, 8'h5C, 8'h5C, 8'h49, 8'h49};
        vecs[3] = '{4'd4,  4'd12, 16'h3333, 2'b01, 8'h4C, 16'hD4C3, 8'h44, 8'hC3, 8'h44, 8'h4C};
        vecs[4] = '{4'd15, 4'd0,  16'h4444, 2'b11, 8'h21, 16'h1234, 8'h4F, 8'h40, 8'h4F, 8'h40};
        vecs[5] = '{4'd6,  4'd6,  16'h5555, 2'b11, 8'h63, 16'h6699, 8'h66, 8'h66, 8'h46, 8'h46};

        reset_n           = 1'b0;
        bus.flush_i       = 1'b0;
        bus.iss_valid_i   = 1'b0;
        bus.iss_src1_i    = '0;
        bus.iss_src2_i    = '0;
        bus.iss_payload_i = '0;
        bus.byp_valid_i   = '0;
        bus.byp_tag_i     = '0;
        bus.byp_data_i    = '0;
        bus.exe_ready_i   = 1'b0;
        tick();
        tick();
        chk("rst_iss_ready", 32'(bus.iss_ready_o), 32'd0);
        chk("rst_exe_valid", 32'(bus.exe_valid_o), 32'd0);
        chk("rst_op1", 32'(bus.exe_op1_o), 32'd0);
        chk("rst_op2", 32'(bus.exe_op2_o), 32'd0);
        chk("rst_payload", 32'(bus.exe_payload_o), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(bus.iss_ready_o), 32'd1);

        // Streaming vectors with execute always ready: each shows up one cycle after issue.
        bus.exe_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.iss_valid_i   = 1'b1;
            bus.iss_src1_i    = vecs[i].src1;
            bus.iss_src2_i    = vecs[i].src2;
            bus.iss_payload_i = vecs[i].pl;
            bus.byp_valid_i   = vecs[i].bv;
            bus.byp_tag_i     = vecs[i].btag;
            bus.byp_data_i    = vecs[i].bdata;
            #1;
            chk($sformatf("v%0d_addr1", i), 32'(bus.prf_addr1_o), 32'(vecs[i].src1));
            chk($sformatf("v%0d_addr2", i), 32'(bus.prf_addr2_o), 32'(vecs[i].src2));
            tick();
            chk($sformatf("v%0d_valid", i), 32'(bus.exe_valid_o), 32'd1);
            chk($sformatf("v%0d_op1", i), 32'(bus.exe_op1_o),
                32'(BypOn ? vecs[i].e1b : vecs[i].e1n));
            chk($sformatf("v%0d_op2", i), 32'(bus.exe_op2_o),
                32'(BypOn ? vecs[i].e2b : vecs[i].e2n));
            chk($sformatf("v%0d_payload", i), 32'(bus.exe_payload_o), 32'(vecs[i].pl));
            chk($sformatf("v%0d_ready", i), 32'(bus.iss_ready_o), 32'd1);
        end
        bus.iss_valid_i = 1'b0;
        bus.byp_valid_i = 2'b00;
        tick();
        chk("drain_valid", 32'(bus.exe_valid_o), 32'd0);
        chk("drain_hold_op1", 32'(bus.exe_op1_o), 32'(BypOn ? vecs[5].e1b : vecs[5].e1n));
        chk("drain_hold_pl", 32'(bus.exe_payload_o), 32'h5555);

        // Backpressure: P0, P1 accepted, P2 refused.
        bus.exe_ready_i = 1'b0;
        issue(16'hA000);
        tick();
        chk("bp_ready_after_p0", 32'(bus.iss_ready_o), 32'd1);
        issue(16'hA001);
        tick();
        chk("bp_ready_after_p1", 32'(bus.iss_ready_o), 32'd0);
        issue(16'hA002);
        tick();
        chk("bp_ready_full", 32'(bus.iss_ready_o), 32'd0);
        chk("bp_head_p0", 32'(bus.exe_payload_o), 32'hA000);
        bus.iss_valid_i = 1'b0;
        bus.exe_ready_i = 1'b1;
        tick();
        chk("bp_head_p1", 32'(bus.exe_payload_o), 32'hA001);
        chk("bp_valid_p1", 32'(bus.exe_valid_o), 32'd1);
        chk("bp_ready_back", 32'(bus.iss_ready_o), 32'd1);
        tick();
        chk("bp_empty", 32'(bus.exe_valid_o), 32'd0);
        chk("bp_no_p2", 32'(bus.exe_payload_o), 32'hA001);

        // count == 1 with push and pop together.
        bus.exe_ready_i = 1'b0;
        issue(16'hC000);
        tick();
        chk("pp_head_q0", 32'(bus.exe_payload_o), 32'hC000);
        issue(16'hC001);
        bus.exe_ready_i = 1'b1;
        tick();
        chk("pp_head_q1", 32'(bus.exe_payload_o), 32'hC001);
        chk("pp_valid", 32'(bus.exe_valid_o), 32'd1);
        chk("pp_ready", 32'(bus.iss_ready_o), 32'd1);
        bus.iss_valid_i = 1'b0;
        bus.exe_ready_i = 1'b0;
        tick();
        chk("pp_hold_q1", 32'(bus.exe_payload_o), 32'hC001);
        bus.exe_ready_i = 1'b1;
        tick();
        chk("pp_single", 32'(bus.exe_valid_o), 32'd0);

        // Flush at count == 2 with an incoming packet.
        bus.exe_ready_i = 1'b0;
        issue(16'hF000);
        tick();
        issue(16'hF001);
        tick();
        issue(16'hF002);
        bus.flush_i = 1'b1;
        tick();
        chk("fl_valid", 32'(bus.exe_valid_o), 32'd0);
        chk("fl_ready", 32'(bus.iss_ready_o), 32'd1);
        bus.flush_i     = 1'b0;
        bus.iss_valid_i = 1'b0;
        tick();
        chk("fl_no_f2", 32'(bus.exe_valid_o), 32'd0);
        // Flush at count == 1 while issue is ready: the incoming packet must be dropped.
        issue(16'hF010);
        tick();
        issue(16'hF011);
        bus.flush_i     = 1'b1;
        bus.exe_ready_i = 1'b1;
        tick();
        chk("fl1_valid", 32'(bus.exe_valid_o), 32'd0);
        bus.flush_i = 1'b0;
        issue(16'hF012);
        tick();
        chk("fl1_restart_pl", 32'(bus.exe_payload_o), 32'hF012);
        chk("fl1_restart_valid", 32'(bus.exe_valid_o), 32'd1);
        bus.iss_valid_i = 1'b0;
        tick();

        // Reset mid-transfer with the buffer full.
        bus.exe_ready_i = 1'b0;
        issue(16'hD000);
        tick();
        issue(16'hD001);
        tick();
        bus.iss_valid_i = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("mr_ready", 32'(bus.iss_ready_o), 32'd0);
        chk("mr_valid", 32'(bus.exe_valid_o), 32'd0);
        chk("mr_op1", 32'(bus.exe_op1_o), 32'd0);
        chk("mr_op2", 32'(bus.exe_op2_o), 32'd0);
        chk("mr_payload", 32'(bus.exe_payload_o), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("mr_ready_back", 32'(bus.iss_ready_o), 32'd1);
        chk("mr_still_empty", 32'(bus.exe_valid_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
